// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: round-robin shared-pump sequencer (prime, water, drain).
// Optional seven-segment area display enabled by defining IRRIG_SEG_EN.
module irrigation_scheduler #(
    parameter int unsigned NAREAS       = 4,
    parameter int unsigned PRIME_CYCLES = 2,
    parameter int unsigned WATER_CYCLES = 8
) (
    input  logic                      clk_2,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NAREAS-1:0]         req,
    output logic [NAREAS-1:0]         valve,
    output logic                      pump,
    output logic                      busy,
    output logic [$clog2(NAREAS)-1:0] area,
    output logic                      done,
    output logic [7:0]                SEG
);

    localparam int unsigned AW   = $clog2(NAREAS);
    localparam int unsigned MAXC = (PRIME_CYCLES > WATER_CYCLES) ? PRIME_CYCLES : WATER_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam logic [NAREAS-1:0] ONE_HOT0 = {{(NAREAS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        WATER = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [NAREAS-1:0] valve_nxt;
    logic              pump_nxt;
    logic              done_nxt;
    logic [AW-1:0]     area_nxt;
    logic [AW-1:0]     last, last_nxt;

    logic              pick_found;
    logic [AW-1:0]     pick_idx;
    logic [AW-1:0]     cand;
    logic              abort;

    // Round-robin search starting one above the last served area, with wrap
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NAREAS; i++) begin
            cand = AW'((32'(last) + i) % NAREAS);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign abort = !enable || !req[area];

    // Next-state and next-output decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valve_nxt = valve;
        pump_nxt  = 1'b0;
        done_nxt  = 1'b0;
        area_nxt  = area;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (enable && pick_found) begin
                    state_nxt = PRIME;
                    area_nxt  = pick_idx;
                    valve_nxt = ONE_HOT0 << pick_idx;
                    cnt_nxt   = '0;
                end
            end
            PRIME: begin
                // Abort wins over expiry here so an aborted grant never pulses the pump
                if (abort) begin
                    state_nxt = DRAIN;
                    done_nxt  = 1'b1;
                end else if (cnt == CW'(PRIME_CYCLES - 1)) begin
                    state_nxt = WATER;
                    cnt_nxt   = '0;
                    pump_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            WATER: begin
                if (abort || (cnt == CW'(WATER_CYCLES - 1))) begin
                    state_nxt = DRAIN;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                    pump_nxt  = 1'b1;
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
                valve_nxt = '0;
                last_nxt  = area;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            valve <= '0;
            pump  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            area  <= '0;
            last  <= AW'(NAREAS - 1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            valve <= valve_nxt;
            pump  <= pump_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= done_nxt;
            area  <= area_nxt;
            last  <= last_nxt;
        end
    end

`ifdef IRRIG_SEG_EN
    logic [7:0] seg_q;

    function automatic logic [7:0] seg_digit(input logic [AW-1:0] a);
        logic [7:0] s;
        s = 8'h00;
        case (32'(a))
            0:       s = 8'h3F;
            1:       s = 8'h06;
            2:       s = 8'h5B;
            3:       s = 8'h4F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Display the granted area while busy, blank in IDLE; moves with valve
    always_ff @(posedge clk_2) begin
        if (reset) begin
            seg_q <= 8'h00;
        end else begin
            seg_q <= (state_nxt != IDLE) ? seg_digit(area_nxt) : 8'h00;
        end
    end

    assign SEG = seg_q;
`else
    assign SEG = 8'h00;
`endif

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler with a grant-order scoreboard.
module tb_irrigation_scheduler;

    localparam int unsigned NAREAS       = 4;
    localparam int unsigned PRIME_CYCLES = 2;
    localparam int unsigned WATER_CYCLES = 8;
    localparam int          FULL_V       = PRIME_CYCLES + WATER_CYCLES + 1;
    localparam int          PERIOD       = PRIME_CYCLES + WATER_CYCLES + 2;
`ifdef IRRIG_SEG_EN
    localparam bit SEG_ON = 1'b1;
`else
    localparam bit SEG_ON = 1'b0;
`endif

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic [3:0] valve;
    logic       pump;
    logic       busy;
    logic [1:0] area;
    logic       done;
    logic [7:0] SEG;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_q[$];

    irrigation_scheduler #(
        .NAREAS       (NAREAS),
        .PRIME_CYCLES (PRIME_CYCLES),
        .WATER_CYCLES (WATER_CYCLES)
    ) dut (
        .clk_2  (clk_2),
        .reset  (reset),
        .enable (enable),
        .req    (req),
        .valve  (valve),
        .pump   (pump),
        .busy   (busy),
        .area   (area),
        .done   (done),
        .SEG    (SEG)
    );

    always #5 clk_2 = ~clk_2;

    always @(posedge clk_2) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] seg_of(input int a, input bit act);
        logic [7:0] s;
        s = 8'h00;
        if (SEG_ON && act) begin
            case (a)
                0: s = 8'h3F;
                1: s = 8'h06;
                2: s = 8'h5B;
                3: s = 8'h4F;
                default: s = 8'h00;
            endcase
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Wait for a grant to start, pop the expected area and check the first busy cycle
    task automatic wait_start(input string tag, output int ea, output int start_cyc);
        bit seen;
        seen = 1'b0;
        ea   = -1;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk_2);
            if (busy === 1'b1) seen = 1'b1;
        end
        start_cyc = cyc;
        check({tag, "_start"}, 32'(seen), 32'd1);
        if (seen) begin
            ea = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check({tag, "_area"},  32'(area),  32'(ea));
            check({tag, "_valve"}, 32'(valve), 32'(4'b0001 << ea));
            check({tag, "_seg"},   32'(SEG),   32'(seg_of(ea, 1'b1)));
        end
    endtask

    // Follow a grant to IDLE, optionally injecting an action at sample index act_at
    task automatic observe(input int ea, input int act_at, input int act,
                           output int vc, output int pc, output int dc, output int pf,
                           output int inv);
        logic [3:0] oh;
        int k;
        oh  = 4'b0001 << ea;
        vc  = 0; pc = 0; dc = 0; pf = -1; inv = 0; k = 0;
        while (busy === 1'b1 && k < 40) begin
            if (valve != 4'b0000) vc++;
            if (valve != 4'b0000 && valve !== oh) inv++;
            if (pump === 1'b1) begin
                pc++;
                if (pf < 0) pf = k;
                if (valve !== oh) inv++;
            end
            if (done === 1'b1) dc++;
            if (k == act_at) begin
                case (act)
                    1: req    = req & ~oh;
                    2: enable = 1'b0;
                    3: reset  = 1'b1;
                    default: ;
                endcase
            end
            @(negedge clk_2);
            k++;
        end
    endtask

    task automatic grant(input string tag, input int act_at, input int act,
                         input int ev, input int ep, input int ed, input int epf,
                         output int start_cyc);
        int ea, vc, pc, dc, pf, inv;
        wait_start(tag, ea, start_cyc);
        observe(ea, act_at, act, vc, pc, dc, pf, inv);
        check({tag, "_end_idle"},   32'(busy), 32'd0);
        check({tag, "_valve_cyc"},  32'(vc),   32'(ev));
        check({tag, "_pump_cyc"},   32'(pc),   32'(ep));
        check({tag, "_done_cnt"},   32'(dc),   32'(ed));
        check({tag, "_pump_first"}, 32'(pf),   32'(epf));
        check({tag, "_onehot"},     32'(inv),  32'd0);
    endtask

    initial begin
        int s_prev, s_cur, busy_seen;

        // Reset with all requests asserted
        reset  = 1'b1;
        enable = 1'b1;
        req    = 4'hF;
        repeat (2) @(negedge clk_2);
        check("rst_valve", 32'(valve), 32'd0);
        check("rst_pump",  32'(pump),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_area",  32'(area),  32'd0);
        check("rst_seg",   32'(SEG),   32'd0);

        // Round-robin with all requests held
        reset = 1'b0;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        s_prev = 0;
        for (int g = 0; g < 5; g++) begin
            grant($sformatf("rr%0d", g), -1, 0, FULL_V, WATER_CYCLES, 1, PRIME_CYCLES, s_cur);
            if (g > 0) check($sformatf("rr%0d_period", g), 32'(s_cur - s_prev), 32'(PERIOD));
            s_prev = s_cur;
        end
        req = 4'h0;

        // Single completed grant on area 2
        req = 4'b0100;
        exp_q.push_back(2);
        grant("single", -1, 0, FULL_V, WATER_CYCLES, 1, PRIME_CYCLES, s_cur);
        req = 4'h0;

        // Request drop in the third WATER cycle of area 1
        req = 4'b0010;
        exp_q.push_back(1);
        grant("reqdrop", PRIME_CYCLES + 2, 1, PRIME_CYCLES + 4, 3, 1, PRIME_CYCLES, s_cur);
        req = 4'h0;

        // Enable drop during PRIME, then stay idle while disabled
        req = 4'hF;
        exp_q.push_back(2);
        grant("endrop", 0, 2, 2, 0, 1, -1, s_cur);
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk_2);
            if (busy !== 1'b0) busy_seen++;
        end
        check("disabled_busy",  32'(busy_seen), 32'd0);
        check("disabled_valve", 32'(valve),     32'd0);

        // Reset in the middle of WATER on area 3
        enable = 1'b1;
        exp_q.push_back(3);
        grant("rstmid", PRIME_CYCLES + 3, 3, PRIME_CYCLES + 4, 4, 0, PRIME_CYCLES, s_cur);
        check("rstmid_valve", 32'(valve), 32'd0);
        check("rstmid_pump",  32'(pump),  32'd0);
        check("rstmid_done",  32'(done),  32'd0);
        check("rstmid_area",  32'(area),  32'd0);
        check("rstmid_seg",   32'(SEG),   32'd0);
        reset = 1'b0;
        exp_q.push_back(0);
        grant("after_rst", -1, 0, FULL_V, WATER_CYCLES, 1, PRIME_CYCLES, s_cur);
        req = 4'h0;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
